uart_line_buffer: RTL and testbench
===================================

# uart_line_buffer

Parametrised byte buffer between the `uart_rx` master stream and the `uart_tx` slave stream, replacing the direct rx→tx loopback wiring in `top`. It honours backpressure from the transmitter instead of tying ready high, so no received byte is lost while the transmitter is busy. It has two modes:

- **Cut-through:** bytes are forwarded as soon as they are stored.
- **Line (store-and-forward):** bytes are released only after a terminator byte has been stored. Lines too long for the buffer are dropped and counted.

## Interface
Parameters:
- `DATA_WIDTH`, 8, stream byte width.
- `DEPTH`, 16, buffer entries; power of two, ≥2.
- `TERM`, 8'h0A, line terminator value (`DATA_WIDTH` bits).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode_i`  in  1  0 = cut-through, 1 = line mode.
- `s_axis_tdata`  in  `DATA_WIDTH`  byte from `uart_rx`.
- `s_axis_tvalid`  in  1  rx byte valid.
- `s_axis_tready`  out  1  buffer accepts the byte.
- `m_axis_tdata`  out  `DATA_WIDTH`  byte to `uart_tx`.
- `m_axis_tvalid`  out  1  committed byte available.
- `m_axis_tready`  in  1  `uart_tx` accepts the byte.
- `level_o`  out  $clog2(DEPTH+1)  total stored entries, committed plus uncommitted.
- `overflow_o`  out  1  one-cycle pulse when a line is dropped.
- `drop_cnt_o`  out  8  count of dropped lines; saturates at 255.

## Operation
- **Storage:** circular buffer with `wr_ptr`, `cm_ptr` (commit) and `rd_ptr`, each $clog2(DEPTH) bits and wrapping modulo `DEPTH`.
  - `cnt` = total entries; `avail` = committed, unread entries. Both range 0..`DEPTH`.
- **Write handshake:** a write occurs when `s_axis_tvalid & s_axis_tready`. It stores the byte at `wr_ptr` and increments `wr_ptr`.
- **Read handshake:** a read occurs when `m_axis_tvalid & m_axis_tready`. It increments `rd_ptr`.
  - `m_axis_tdata` = mem[`rd_ptr`].
  - `m_axis_tvalid` = (`avail` ≠ 0).
- **Active mode:** `mode_q` is loaded from `mode_i` only when the uncommitted count is 0 and the state is RUN; otherwise it holds its value. `mode_q` resets to 0.
- **Cut-through** (`mode_q` = 0):
  - `s_axis_tready` = (`cnt` ≠ `DEPTH`).
  - Every write also commits, so `cm_ptr` follows `wr_ptr`.
- **Line mode** (`mode_q` = 1): `s_axis_tready` = 1 always, so the receiver is never stalled and a deadlock on a full buffer is impossible.
  - A write of byte == `TERM` commits the line: `cm_ptr` takes the new `wr_ptr`, and the terminator itself is transmitted.
  - A write while `cnt` == `DEPTH`:
    - rewind `wr_ptr` to `cm_ptr`, discarding the uncommitted bytes;
    - pulse `overflow_o`;
    - increment `drop_cnt_o`, saturating at 255;
    - go to DISCARD.
  - The discarding write is not stored.
- **State machine** (line mode only):
  - RUN → DISCARD on an overflowing write.
  - DISCARD: every accepted byte is discarded. A `TERM` byte is also discarded, and the state returns to RUN.
- **Simultaneous write and read in one cycle:**
  - `cnt` is unchanged; `avail` changes by (commit size − 1).
  - A read freeing an entry in the same cycle as a write at `cnt` == `DEPTH`: the full test uses `cnt` before the update, so the write overflows. This is a deliberate, simple rule.

## Timing
- Reset values:
  - `s_axis_tready` = 1;
  - `m_axis_tvalid` = 0, `m_axis_tdata` = mem[0] (don't-care);
  - `level_o` = 0, `overflow_o` = 0, `drop_cnt_o` = 0;
  - all pointers 0, state RUN, `mode_q` = 0.
- Latency, cut-through, empty buffer: a byte written at edge N is on `m_axis_*` with valid high right after edge N (valid during cycle N+1).
- Latency, line mode: the whole line becomes valid right after the edge that writes `TERM`.
- `overflow_o` is high for exactly the cycle after the overflowing write edge.
- `m_axis_tdata` and `m_axis_tvalid` are stable while `m_axis_tvalid` is high and `m_axis_tready` is low.
- Reset during operation clears all stored data within one edge. No partial line survives reset.

## Structure
- Package `uart_line_pkg` holds:
  - `typedef enum logic {MODE_CUT, MODE_LINE} mode_e`;
  - `typedef enum logic {ST_RUN, ST_DISCARD} state_e`;
  - the `DEFAULT_TERM` constant.
- Sub-module `uart_line_ram`: `DEPTH` × `DATA_WIDTH` memory with a synchronous write port and an asynchronous read port, no reset on contents (maps to iCE40 logic at `DEPTH` 16).
- `uart_line_buffer` holds the pointers, counters, FSM and handshake logic.
- `top` instantiates it between `uart_rx` and `uart_tx`, with `prescale` unchanged.

## Test plan
- **Cut-through passthrough:** mode 0, write 0x41, 0x42, 0x43 with `m_axis_tready` = 1 → the same bytes in order, each valid one cycle after its write; `level_o` returns to 0.
- **Backpressure fill:** mode 0, `m_axis_tready` = 0, write 17 bytes → `s_axis_tready` goes low after the 16th write and `level_o` = 16. Raise ready → all 16 bytes drain in order, and the 17th byte is then accepted.
- **Line commit:** mode 1, write "HI" then 0x0A with ready = 1 → `m_axis_tvalid` stays 0 until the edge writing 0x0A, then 0x48, 0x49, 0x0A are sent back to back.
- **Line overflow:** mode 1, ready = 0, write 17 non-terminator bytes → one `overflow_o` pulse, `drop_cnt_o` = 1, `level_o` = 0. Then write "A" and 0x0A (discarded) followed by "B" and 0x0A → only 0x42, 0x0A are sent.
- **Wrap and simultaneous operation:** mode 0, sustained random valid/ready for 1000 bytes → scoreboard shows no loss or reordering, and `level_o` matches the model every cycle.
- **Reset mid-line:** mode 1, write 3 bytes, assert `rst` for one cycle, then send 0x0A → `m_axis_tvalid` = 0 after reset, and only 0x0A is sent.

Source files
------------

// File: rtl/uart_line_pkg.sv
// Shared types and constants for the UART line buffer.
package uart_line_pkg;

    typedef enum logic {MODE_CUT, MODE_LINE} mode_e;
    typedef enum logic {ST_RUN, ST_DISCARD} state_e;

    localparam logic [7:0] DEFAULT_TERM = 8'h0A;
    localparam int unsigned DROP_W = 8;

endpackage

// File: rtl/uart_line_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, contents not reset.
module uart_line_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_buffer.sv
// Byte buffer between uart_rx and uart_tx with cut-through and store-and-forward line modes.
module uart_line_buffer
    import uart_line_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] TERM      = DATA_WIDTH'(DEFAULT_TERM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode_i,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o,
    output logic [DROP_W-1:0]            drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] cm_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] avail;
    state_e           state_q;
    mode_e            mode_q;

    logic             wr_fire;
    logic             rd_fire;
    logic             is_term;
    logic             full;
    logic             store;
    logic             commit;
    logic             overflow;
    logic [CNT_W-1:0] uncommitted;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] cm_ptr_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] avail_next;
    state_e           state_next;
    mode_e            mode_next;
    logic             tready_next;

    uart_line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr),
        .rdata (m_axis_tdata)
    );

    // Next-state for pointers, counts, mode and discard FSM.
    always_comb begin
        wr_fire     = s_axis_tvalid & s_axis_tready;
        rd_fire     = m_axis_tvalid & m_axis_tready;
        is_term     = (s_axis_tdata == TERM);
        full        = (cnt == CNT_W'(DEPTH));
        uncommitted = cnt - avail;
        wr_ptr_inc  = wr_ptr + PTR_W'(1);
        store       = 1'b0;
        commit      = 1'b0;
        overflow    = 1'b0;
        state_next  = state_q;
        wr_ptr_next = wr_ptr;
        cm_ptr_next = cm_ptr;
        cnt_next    = cnt;
        avail_next  = avail;
        mode_next   = mode_q;

        if (wr_fire) begin
            if (mode_q == MODE_CUT) begin
                store  = 1'b1;
                commit = 1'b1;
            end else if (state_q == ST_DISCARD) begin
                if (is_term) begin
                    state_next = ST_RUN;
                end
            end else if (full) begin
                // Full test uses the pre-update count even if a read frees a slot now.
                overflow   = 1'b1;
                state_next = ST_DISCARD;
            end else begin
                store  = 1'b1;
                commit = is_term;
            end
        end

        if (overflow) begin
            wr_ptr_next = cm_ptr;
            cnt_next    = avail;
        end else if (store) begin
            wr_ptr_next = wr_ptr_inc;
            cnt_next    = cnt + CNT_W'(1);
        end

        // A commit releases every pending byte plus the one being written.
        if (commit) begin
            cm_ptr_next = wr_ptr_inc;
            avail_next  = avail + uncommitted + CNT_W'(1);
        end

        if (rd_fire) begin
            cnt_next   = cnt_next - CNT_W'(1);
            avail_next = avail_next - CNT_W'(1);
        end

        // Mode only switches on a line boundary with no write in flight.
        if (state_q == ST_RUN && uncommitted == '0 && !wr_fire) begin
            mode_next = mode_e'(mode_i);
        end

        tready_next = (mode_next == MODE_LINE) || (cnt_next != CNT_W'(DEPTH));
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            cm_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            avail         <= '0;
            state_q       <= ST_RUN;
            mode_q        <= MODE_CUT;
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= 1'b0;
            overflow_o    <= 1'b0;
            drop_cnt_o    <= '0;
        end else begin
            wr_ptr        <= wr_ptr_next;
            cm_ptr        <= cm_ptr_next;
            cnt           <= cnt_next;
            avail         <= avail_next;
            state_q       <= state_next;
            mode_q        <= mode_next;
            s_axis_tready <= tready_next;
            m_axis_tvalid <= (avail_next != '0);
            overflow_o    <= overflow;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (overflow && drop_cnt_o != {DROP_W{1'b1}}) begin
                drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            end
        end
    end

    assign level_o = cnt;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Scoreboard bench for uart_line_buffer: expected bytes queued on write, compared on read.
module tb_uart_line_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_i;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [4:0] level_o;
    logic       overflow_o;
    logic [7:0] drop_cnt_o;

    uart_line_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .mode_i        (mode_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .level_o       (level_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    bit         push_on_wr = 0;
    bit         track_level = 0;
    int         lvl_model = 0;
    bit         last_wr;
    bit         last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: resolve handshakes from stable pre-edge values, then step past the edge.
    task automatic cycle();
        logic [7:0] exp;
        last_wr = s_axis_tvalid & s_axis_tready;
        last_rd = m_axis_tvalid & m_axis_tready;
        if (last_rd) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("rd_data", 32'(m_axis_tdata), 32'(exp));
            end
        end
        if (last_wr && push_on_wr) sb.push_back(s_axis_tdata);
        @(posedge clk);
        #1;
        if (track_level) begin
            lvl_model = lvl_model + int'(last_wr) - int'(last_rd);
            check("level_model", 32'(level_o), 32'(lvl_model));
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        cycle();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        m_axis_tready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int ov_pulses;
        int acc;
        int n;
        bit got17;

        rst = 1'b1; mode_i = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready",  32'(s_axis_tready), 32'd1);
        check("rst_m_valid",  32'(m_axis_tvalid), 32'd0);
        check("rst_level",    32'(level_o),       32'd0);
        check("rst_overflow", 32'(overflow_o),    32'd0);
        check("rst_drop",     32'(drop_cnt_o),    32'd0);
        rst = 1'b0;

        // Cut-through passthrough
        m_axis_tready = 1'b1;
        push_on_wr    = 1;
        write_byte(8'h41);
        check("ct_latency_valid", 32'(m_axis_tvalid), 32'd1);
        check("ct_latency_data",  32'(m_axis_tdata),  32'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        drain("ct_drain");
        cycle();
        check("ct_level0", 32'(level_o), 32'd0);

        // Backpressure fill
        m_axis_tready = 1'b0;
        acc = 0; n = 0;
        s_axis_tvalid = 1'b1;
        while (acc < 16 && n < 100) begin
            s_axis_tdata = 8'(8'h10 + acc);
            cycle();
            if (last_wr) acc++;
            n++;
        end
        check("bp_s_ready_low", 32'(s_axis_tready), 32'd0);
        check("bp_level16",     32'(level_o),       32'd16);
        s_axis_tdata = 8'h20;
        cycle();
        check("bp_hold_17", 32'(last_wr), 32'd0);
        check("bp_level_hold", 32'(level_o), 32'd16);
        m_axis_tready = 1'b1;
        got17 = 0; n = 0;
        while (!(got17 && sb.size() == 0) && n < 100) begin
            cycle();
            if (last_wr) begin
                got17 = 1;
                s_axis_tvalid = 1'b0;
            end
            n++;
        end
        check("bp_17_accepted", 32'(got17), 32'd1);
        check("bp_drained",     32'(sb.size()), 32'd0);
        check("bp_level0",      32'(level_o), 32'd0);

        // Line commit
        push_on_wr = 0;
        mode_i = 1'b1;
        cycle();
        write_byte(8'h48);
        check("ln_hold_after_H", 32'(m_axis_tvalid), 32'd0);
        write_byte(8'h49);
        check("ln_hold_after_I", 32'(m_axis_tvalid), 32'd0);
        sb.push_back(8'h48); sb.push_back(8'h49); sb.push_back(8'h0A);
        write_byte(8'h0A);
        check("ln_commit_valid", 32'(m_axis_tvalid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("ln_back_to_back", 32'(m_axis_tvalid), 32'd1);
            cycle();
        end
        check("ln_done_valid", 32'(m_axis_tvalid), 32'd0);
        check("ln_sb_empty",   32'(sb.size()),     32'd0);

        // Line overflow
        m_axis_tready = 1'b0;
        ov_pulses = 0;
        for (int i = 0; i < 17; i++) begin
            write_byte(8'(8'h60 + i));
            if (overflow_o) ov_pulses++;
        end
        check("ov_pulse_now", 32'(overflow_o), 32'd1);
        check("ov_drop1",     32'(drop_cnt_o), 32'd1);
        check("ov_level0",    32'(level_o),    32'd0);
        cycle();
        if (overflow_o) ov_pulses++;
        check("ov_one_pulse", 32'(ov_pulses),  32'd1);
        check("ov_pulse_end", 32'(overflow_o), 32'd0);
        write_byte(8'h41);
        write_byte(8'h0A);
        check("ov_discard_valid", 32'(m_axis_tvalid), 32'd0);
        check("ov_discard_level", 32'(level_o),       32'd0);
        sb.push_back(8'h42); sb.push_back(8'h0A);
        write_byte(8'h42);
        write_byte(8'h0A);
        check("ov_b_line_level", 32'(level_o), 32'd2);
        drain("ov_drain");
        check("ov_drop_still1", 32'(drop_cnt_o), 32'd1);

        // Random cut-through with wrap and simultaneous traffic
        mode_i = 1'b0;
        m_axis_tready = 1'b0;
        cycle();
        check("rnd_start_level", 32'(level_o), 32'd0);
        push_on_wr = 1; track_level = 1; lvl_model = 0;
        acc = 0; n = 0;
        while (acc < 1000 && n < 20000) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = 8'($urandom);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_wr) acc++;
            n++;
        end
        check("rnd_bytes_sent", 32'(acc), 32'd1000);
        s_axis_tvalid = 1'b0;
        drain("rnd_drain");
        track_level = 0;
        check("rnd_level0", 32'(level_o), 32'd0);

        // Reset mid-line
        push_on_wr = 0;
        mode_i = 1'b1;
        cycle();
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        check("rm_level3", 32'(level_o), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rm_valid0", 32'(m_axis_tvalid), 32'd0);
        check("rm_level0", 32'(level_o),       32'd0);
        cycle();
        sb.push_back(8'h0A);
        write_byte(8'h0A);
        check("rm_term_valid", 32'(m_axis_tvalid), 32'd1);
        check("rm_term_level", 32'(level_o),       32'd1);
        drain("rm_drain");
        cycle();
        check("rm_final_valid", 32'(m_axis_tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
